// File: rtl/serial_pkg.sv
// Shared constants for the serial shift-in receiver: FSM encoding, line idle
// levels and bit-counter width.
package serial_pkg;

  localparam int unsigned BITCNT_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  localparam logic IDLE_S_CLK  = 1'b0;
  localparam logic IDLE_S_DAT  = 1'b0;
  localparam logic IDLE_S_PEN  = 1'b0;
  localparam logic IDLE_S_CLRN = 1'b1;

  function automatic logic [BITCNT_W-1:0] sat_inc(input logic [BITCNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/serial_shift_rx_if.sv
// 4-wire serial frame lines plus the parallel result seen by the MIO bus.
interface serial_shift_rx_if #(
  parameter int unsigned WIDTH = 16
);
  import serial_pkg::*;

  logic                s_clk;
  logic                s_dat;
  logic                s_pen;
  logic                s_clrn;
  logic [WIDTH-1:0]    data_out;
  logic                data_valid;
  logic                frame_err;
  logic [BITCNT_W-1:0] bit_cnt;

  modport master (
    output s_clk, s_dat, s_pen, s_clrn,
    input  data_out, data_valid, frame_err, bit_cnt
  );

  modport slave (
    input  s_clk, s_dat, s_pen, s_clrn,
    output data_out, data_valid, frame_err, bit_cnt
  );

endinterface

// File: rtl/sync_edge_det.sv
// N-stage synchroniser with a one-cycle rising-edge pulse on its output.
module sync_edge_det #(
  parameter int unsigned STAGES   = 2,
  parameter logic        IDLE_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{IDLE_LVL}};
      hist  <= IDLE_LVL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      hist  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~hist;

endmodule

// File: rtl/serial_shift_rx.sv
// Oversampling deserialiser for the LED/7-seg shift-out protocol; presents the
// parallel word on the latch edge and flags frames with the wrong bit count.
module serial_shift_rx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  serial_shift_rx_if.slave    bus
);

  logic                   clk_s, clk_rise;
  logic                   pen_s, pen_rise;
  logic [SYNC_STAGES-1:0] dat_sync, clrn_sync;
  logic                   dat_s, clrn_s;

  logic [1:0]             state;
  logic [WIDTH-1:0]       shreg, sh_next;
  logic [BITCNT_W-1:0]    cnt, cnt_next;

  sync_edge_det #(.STAGES(SYNC_STAGES), .IDLE_LVL(IDLE_S_CLK)) u_clk_sync (
    .clk(clk), .rst(rst), .d(bus.s_clk), .q(clk_s), .rise(clk_rise)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .IDLE_LVL(IDLE_S_PEN)) u_pen_sync (
    .clk(clk), .rst(rst), .d(bus.s_pen), .q(pen_s), .rise(pen_rise)
  );

  // Data and clear only need level synchronisation; data is tapped at the same
  // depth as s_clk so the sample coincides with the detected rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_sync  <= {SYNC_STAGES{IDLE_S_DAT}};
      clrn_sync <= {SYNC_STAGES{IDLE_S_CLRN}};
    end else begin
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], bus.s_dat};
      clrn_sync <= {clrn_sync[SYNC_STAGES-2:0], bus.s_clrn};
    end
  end

  assign dat_s  = dat_sync[SYNC_STAGES-1];
  assign clrn_s = clrn_sync[SYNC_STAGES-1];

  // The shift is resolved before the latch so a coincident s_clk/s_pen edge
  // latches the updated register and count.
  always_comb begin
    sh_next  = shreg;
    cnt_next = cnt;
    if (clk_rise) begin
      if (MSB_FIRST) sh_next = {shreg[WIDTH-2:0], dat_s};
      else           sh_next = {dat_s, shreg[WIDTH-1:1]};
      cnt_next = sat_inc(cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      shreg          <= '0;
      cnt            <= '0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      bus.data_valid <= 1'b0;
      if (!clrn_s) begin
        state <= ST_IDLE;
        shreg <= '0;
        cnt   <= '0;
      end else if (pen_rise && state != ST_LATCH) begin
        if (cnt_next == BITCNT_W'(WIDTH)) begin
          bus.data_out   <= sh_next;
          bus.data_valid <= 1'b1;
          bus.frame_err  <= 1'b0;
        end else begin
          bus.frame_err  <= 1'b1;
        end
        state <= ST_LATCH;
        shreg <= '0;
        cnt   <= '0;
      end else if (clk_rise) begin
        state <= ST_SHIFT;
        shreg <= sh_next;
        cnt   <= cnt_next;
      end else if (state == ST_LATCH) begin
        state <= ST_IDLE;
      end
    end
  end

  assign bus.bit_cnt = cnt;

endmodule

// File: doc/serial_shift_rx.md
Name: serial_shift_rx

Overview:
- Receive-side counterpart of the serial shift-out peripherals (LED and 7-segment drivers: led_clk/led_sout/LED_PEN/led_clrn, seg_clk/seg_sout/SEG_PEN/seg_clrn).
- Oversamples the 4-wire serial frame in the system clock domain, deserialises it, and on the latch (PEN) edge presents the parallel word.
- Used as an on-board loopback checker and as the input stage of a serial daughterboard; the parallel word is read through the MIO bus.

Parameters:
- WIDTH, 16, payload bits per frame (16 = LED chain, 64 = 7-seg chain).
- MSB_FIRST, 1, 1: first received bit lands in data_out[WIDTH-1]; 0: first bit lands in data_out[0].
- SYNC_STAGES, 2, synchroniser depth on each serial input (minimum 2).

Ports:
- clk  in  1  system clock (100 MHz); all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_clk  in  1  serial shift clock; data is sampled on its rising edge.
- s_dat  in  1  serial data.
- s_pen  in  1  parallel-enable/latch; a rising edge ends the frame.
- s_clrn  in  1  active-low clear of the shift chain.
- data_out  out  WIDTH  last correctly framed word.
- data_valid  out  1  one-cycle pulse when data_out updates.
- frame_err  out  1  sticky flag: last latch had bit count != WIDTH.
- bit_cnt  out  8  bits shifted since the last clear or latch; saturates at 255.

Behaviour:
- Synchronisation
  - s_clk, s_dat, s_pen and s_clrn each pass through SYNC_STAGES flops, plus one history flop for edge detection.
  - Pin-to-action latency is SYNC_STAGES+1 clk cycles.
  - s_dat is sampled from the same synchroniser stage as s_clk, so the sample is taken at the detected edge.
- FSM states
  - IDLE: after rst, clear or latch.
  - SHIFT: at least one bit received.
  - LATCH: one cycle; evaluates the frame and returns to IDLE.
- Shifting
  - Each detected s_clk rise: the shift register takes s_dat. MSB_FIRST=1 shifts left with the new bit entering bit 0. MSB_FIRST=0 shifts right with the new bit entering bit WIDTH-1.
  - Each rise also increments bit_cnt (saturating) and moves IDLE to SHIFT.
  - Overrun (>WIDTH bits): shifting continues, so the register holds the last WIDTH bits; bit_cnt still counts.
- Latch, on a detected s_pen rise, from IDLE or SHIFT
  - bit_cnt == WIDTH: data_out <= shift register; data_valid=1 for exactly the next cycle; frame_err cleared.
  - bit_cnt != WIDTH (includes 0): data_out holds; data_valid stays 0; frame_err set.
  - In both cases the shift register and bit_cnt clear, and the FSM enters LATCH, then IDLE.
- Simultaneous events in the same cycle
  - s_clk rise and s_pen rise: the shift is applied first, and the latch evaluates the updated register and count.
  - s_clrn low (synced): dominates. The shift register and bit_cnt clear, s_clk and s_pen edges are ignored, and the FSM goes to IDLE.
  - s_clrn low does not alter data_out, data_valid or frame_err.
- Reset (rst=1, synchronous, any state including mid-frame)
  - data_out=0, data_valid=0, frame_err=0, bit_cnt=0, shift register=0.
  - Synchronisers load idle levels: s_clk=0, s_pen=0, s_clrn=1, s_dat=0. This guarantees no spurious edge in the cycle after reset.
- Input rate: the s_clk high and low phases must each last at least SYNC_STAGES+1 clk cycles. Shorter pulses are undefined behaviour and are not detected.

Decomposition:
- Shared package serial_pkg:
  - State encoding: ST_IDLE, ST_SHIFT, ST_LATCH.
  - Idle-level constants for the four serial lines.
  - BITCNT_W = 8.
- One sub-module, sync_edge_det: an N-stage synchroniser with rise-pulse output, instantiated for s_clk and s_pen. s_dat and s_clrn use its synchronised output only.

Test Plan:
- WIDTH=16, MSB_FIRST=1; shift 0xA5C3 MSB first, then pulse s_pen -> data_out=0xA5C3; data_valid high exactly 1 cycle, SYNC_STAGES+1 cycles after the s_pen edge; frame_err=0; bit_cnt returns to 0.
- Shift 15 bits of 0x1234, then pulse s_pen -> data_out keeps the previous 0xA5C3; frame_err=1; no data_valid. Next, a correct 16-bit frame 0xFFFF -> data_out=0xFFFF and frame_err=0.
- Shift 20 bits (0xF followed by 0xBEEF), then pulse s_pen -> frame_err=1, bit_cnt reads 20 before the latch, data_out unchanged.
- Shift 8 bits, drop s_clrn low for 5 cycles, then shift 0x00FF as 16 bits and latch -> data_out=0x00FF, frame_err=0.
- Assert rst mid-frame after 10 bits -> all outputs 0 the next cycle; a subsequent full frame 0x8001 latches correctly with no spurious bit from the reset release.
- WIDTH=64, MSB_FIRST=0; send 0x0123456789ABCDEF LSB first with s_clk and the 64th-bit edge coincident with the s_pen rise -> data_out=0x0123456789ABCDEF and data_valid=1.
